// File: rtl/ahb_data_slave.sv
// ahb_data_slave: AHB-Lite slave in front of a small word buffer. Each OKAY
// transfer has a configurable number of wait states. Misaligned or
// out-of-range accesses get a two-cycle ERROR response. Completed OKAY reads
// and writes are counted.
//
// Ports:
//   hclk, hrst           clock, asynchronous active-low reset
//   hsel, htrans, haddr  address phase, qualified by hready
//   hwrite, hready
//   hwdata               write data, data phase
//   hreadyout, hresp     data-phase completion and response
//   hrdata               read data, non-zero only in a read data cycle
//   wr_count, rd_count   completed OKAY write/read counters, wrap at 8 bits
module ahb_data_slave #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        hclk,
  input  logic        hrst,
  input  logic        hsel,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic        hready,
  input  logic [31:0] hwdata,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata,
  output logic [7:0]  wr_count,
  output logic [7:0]  rd_count
);

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned WAIT_W     = 3;
  localparam int unsigned WORD_IDX_W = 30;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                write_q, write_d;
  logic [CNT_W-1:0]    wr_count_q, wr_count_d;
  logic [CNT_W-1:0]    rd_count_q, rd_count_d;
  logic                hreadyout_q, hreadyout_d;
  logic                hresp_q, hresp_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];

  logic                  addr_phase;
  logic [WORD_IDX_W-1:0] word_idx;
  logic                  addr_ok;
  logic                  take_new;

  // Address-phase decode: a transfer is present only when the bus is ready.
  always_comb begin
    addr_phase = hsel && hready && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    word_idx   = WORD_IDX_W'((haddr - BASE_ADDR) >> 2);
    addr_ok    = (haddr[1:0] == 2'b00) && (word_idx < WORD_IDX_W'(DEPTH));
  end

  // Next-state, buffer update and counters.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    idx_d      = idx_q;
    write_d    = write_q;
    wr_count_d = wr_count_q;
    rd_count_d = rd_count_q;
    mem_d      = mem_q;
    take_new   = 1'b0;

    unique case (state_q)
      S_IDLE: take_new = 1'b1;
      S_WAIT: begin
        if (wait_cnt_q == '0) begin
          state_d = S_DATA;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end
      S_DATA: begin
        if (write_q) begin
          mem_d[idx_q] = hwdata;
          wr_count_d   = wr_count_q + CNT_W'(1);
        end else begin
          rd_count_d   = rd_count_q + CNT_W'(1);
        end
        state_d  = S_IDLE;
        take_new = 1'b1;
      end
      S_ERR1: state_d = S_ERR2;
      S_ERR2: begin
        state_d  = S_IDLE;
        take_new = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // A new address phase can only land in a cycle that shows hreadyout=1.
    if (take_new && addr_phase) begin
      idx_d   = IDX_W'(word_idx);
      write_d = hwrite;
      if (!addr_ok) begin
        state_d = S_ERR1;
      end else if (WAIT_STATES > 0) begin
        // Counter runs WAIT_STATES-1 down to 0, giving WAIT_STATES wait cycles.
        state_d    = S_WAIT;
        wait_cnt_d = WAIT_W'(WAIT_STATES - 1);
      end else begin
        state_d = S_DATA;
      end
    end

    hreadyout_d = (state_d == S_IDLE) || (state_d == S_DATA) || (state_d == S_ERR2);
    hresp_d     = (state_d == S_ERR1) || (state_d == S_ERR2);
  end

  // State and buffer registers; reset clears everything, including the buffer.
  always_ff @(posedge hclk or negedge hrst) begin
    if (!hrst) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      idx_q       <= '0;
      write_q     <= 1'b0;
      wr_count_q  <= '0;
      rd_count_q  <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      idx_q       <= idx_d;
      write_q     <= write_d;
      wr_count_q  <= wr_count_d;
      rd_count_q  <= rd_count_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Read data is taken from the buffer during the read data cycle, so a write
  // that completed on the previous edge is already visible.
  assign hrdata    = ((state_q == S_DATA) && !write_q) ? mem_q[idx_q] : '0;
  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign wr_count  = wr_count_q;
  assign rd_count  = rd_count_q;

endmodule
